// File: rtl/modport_fifo_pkg.sv
// Shared widths and types for the modport_fifo slice.
// Optional error flags are enabled by defining MODPORT_FIFO_ERR_FLAGS_EN.
package modport_fifo_pkg;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned DEPTH  = 8;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned PTR_W  = 3;

  typedef logic [DATA_W-1:0] data_t;
  typedef logic [CNT_W-1:0]  cnt_t;
  typedef logic [PTR_W-1:0]  ptr_t;
endpackage

// File: rtl/modport_fifo_if.sv
// Producer/consumer handshake bundle for modport_fifo.
// overflow/underflow exist only when MODPORT_FIFO_ERR_FLAGS_EN is defined.
interface modport_fifo_if;
  import modport_fifo_pkg::*;

  logic  wr_enb;
  data_t data_in;
  logic  rd_enb;
  data_t data_out;
  logic  empty;
  logic  full;
  cnt_t  count;
`ifdef MODPORT_FIFO_ERR_FLAGS_EN
  logic  overflow;
  logic  underflow;
`endif

`ifdef MODPORT_FIFO_ERR_FLAGS_EN
  modport master (
    output wr_enb, data_in, rd_enb,
    input  data_out, empty, full, count, overflow, underflow
  );
  modport slave (
    input  wr_enb, data_in, rd_enb,
    output data_out, empty, full, count, overflow, underflow
  );
`else
  modport master (
    output wr_enb, data_in, rd_enb,
    input  data_out, empty, full, count
  );
  modport slave (
    input  wr_enb, data_in, rd_enb,
    output data_out, empty, full, count
  );
`endif
endinterface

// File: rtl/modport_fifo_mem.sv
// DEPTH x DATA_W register array: one write port, one registered read port.
// Storage is never reset; only the read register clears on reset.
module modport_fifo_mem
  import modport_fifo_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  wr_en,
  input  ptr_t  wr_addr,
  input  data_t wr_data,
  input  logic  rd_en,
  input  ptr_t  rd_addr,
  output data_t rd_data
);
  data_t mem_q [DEPTH];
  data_t mem_d [DEPTH];
  data_t rd_data_q, rd_data_d;

  // Read samples the pre-write contents, so a full-FIFO read+write to the
  // same slot returns the oldest word.
  always_comb begin
    mem_d     = mem_q;
    rd_data_d = rd_data_q;
    if (wr_en) mem_d[wr_addr] = wr_data;
    if (rd_en) rd_data_d = mem_q[rd_addr];
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_data_q <= '0;
    else        rd_data_q <= rd_data_d;
  end

  assign rd_data = rd_data_q;
endmodule

// File: rtl/modport_fifo.sv
// Single-clock 8x8 FIFO with registered data, flags and occupancy count.
// Define MODPORT_FIFO_ERR_FLAGS_EN to add one-cycle overflow/underflow pulses.
module modport_fifo
  import modport_fifo_pkg::*;
(
  input logic           clk,
  input logic           reset,
  modport_fifo_if.slave bus
);
  ptr_t  wr_ptr_q, wr_ptr_d;
  ptr_t  rd_ptr_q, rd_ptr_d;
  cnt_t  count_q,  count_d;
  logic  empty_q,  empty_d;
  logic  full_q,   full_d;
  logic  wr_acc,   rd_acc;
  data_t rd_data;

  // A write into a full FIFO is still legal when a read frees a slot.
  always_comb begin
    wr_acc   = bus.wr_enb && (!full_q || bus.rd_enb);
    rd_acc   = bus.rd_enb && !empty_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_acc) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (rd_acc) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (wr_acc && !rd_acc)      count_d = count_q + cnt_t'(1);
    else if (rd_acc && !wr_acc) count_d = count_q - cnt_t'(1);
    empty_d = (count_d == '0);
    full_d  = (count_d == cnt_t'(DEPTH));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
    end
  end

  modport_fifo_mem u_mem (
    .clk     (clk),
    .rst_n   (reset),
    .wr_en   (wr_acc),
    .wr_addr (wr_ptr_q),
    .wr_data (bus.data_in),
    .rd_en   (rd_acc),
    .rd_addr (rd_ptr_q),
    .rd_data (rd_data)
  );

  assign bus.data_out = rd_data;
  assign bus.count    = count_q;
  assign bus.empty    = empty_q;
  assign bus.full     = full_q;

`ifdef MODPORT_FIFO_ERR_FLAGS_EN
  logic overflow_q,  overflow_d;
  logic underflow_q, underflow_d;

  always_comb begin
    overflow_d  = bus.wr_enb && full_q && !bus.rd_enb;
    underflow_d = bus.rd_enb && empty_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;
`endif
endmodule

// File: tb/tb_modport_fifo.sv
// Directed self-checking bench for modport_fifo; covers MODPORT_FIFO_ERR_FLAGS_EN when defined.
module tb_modport_fifo;
  import modport_fifo_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   total = 0;
  int   bad = 0;
  data_t q[$];
  data_t exp_d;

  modport_fifo_if bus();

  modport_fifo dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic wr, input data_t d, input logic rd);
    bus.wr_enb  = wr;
    bus.data_in = d;
    bus.rd_enb  = rd;
  endtask

  initial begin
    drive(1'b0, '0, 1'b0);
    step();
    step();
    chk("rst_hold_empty", bus.empty, 1);
    chk("rst_hold_count", bus.count, 0);
    reset = 1'b1;
    step();
    chk("rst_empty", bus.empty, 1);
    chk("rst_full", bus.full, 0);
    chk("rst_count", bus.count, 0);
    chk("rst_dout", bus.data_out, 0);

    // Fill 0x11..0x88
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, data_t'((i + 1) * 8'h11), 1'b0);
      step();
      chk("fill_count", bus.count, i + 1);
      chk("fill_full", bus.full, (i == 7) ? 1 : 0);
      chk("fill_empty", bus.empty, 0);
    end

    // Write while full is dropped
    drive(1'b1, 8'hFF, 1'b0);
    step();
    chk("ovf_count", bus.count, 8);
    chk("ovf_full", bus.full, 1);
`ifdef MODPORT_FIFO_ERR_FLAGS_EN
    chk("ovf_pulse", bus.overflow, 1);
`endif
    drive(1'b0, '0, 1'b0);
    step();
`ifdef MODPORT_FIFO_ERR_FLAGS_EN
    chk("ovf_clear", bus.overflow, 0);
`endif

    for (int i = 0; i < 8; i++) begin
      drive(1'b0, '0, 1'b1);
      step();
      chk("drain_data", bus.data_out, (i + 1) * 8'h11);
      chk("drain_count", bus.count, 7 - i);
    end
    chk("drain_empty", bus.empty, 1);
    chk("drain_full", bus.full, 0);

    // Read while empty is ignored
    drive(1'b0, '0, 1'b1);
    step();
    chk("udf_dout", bus.data_out, 8'h88);
    chk("udf_count", bus.count, 0);
    chk("udf_empty", bus.empty, 1);
`ifdef MODPORT_FIFO_ERR_FLAGS_EN
    chk("udf_pulse", bus.underflow, 1);
`endif
    drive(1'b0, '0, 1'b0);
    step();
`ifdef MODPORT_FIFO_ERR_FLAGS_EN
    chk("udf_clear", bus.underflow, 0);
`endif

    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, data_t'(i), 1'b0);
      step();
    end
    chk("c4_count", bus.count, 4);
    drive(1'b1, 8'hA5, 1'b1);
    step();
    chk("c4_rw_count", bus.count, 4);
    chk("c4_rw_dout", bus.data_out, 8'h01);

    for (int i = 5; i <= 8; i++) begin
      drive(1'b1, data_t'(i), 1'b0);
      step();
    end
    chk("full2_count", bus.count, 8);
    drive(1'b1, 8'h5A, 1'b1);
    step();
    chk("full_rw_count", bus.count, 8);
    chk("full_rw_full", bus.full, 1);
    chk("full_rw_dout", bus.data_out, 8'h02);

    q = '{8'h03, 8'h04, 8'hA5, 8'h05, 8'h06, 8'h07, 8'h08, 8'h5A};
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, '0, 1'b1);
      step();
      exp_d = q.pop_front();
      chk("full_rw_drain", bus.data_out, exp_d);
    end
    chk("full_rw_empty", bus.empty, 1);

    // Empty + write + read: only the write happens
    drive(1'b1, 8'h33, 1'b1);
    step();
    chk("e_rw_count", bus.count, 1);
    chk("e_rw_dout", bus.data_out, 8'h5A);
    chk("e_rw_empty", bus.empty, 0);
    drive(1'b0, '0, 1'b1);
    step();
    chk("e_rw_read", bus.data_out, 8'h33);
    chk("e_rw_count0", bus.count, 0);

    // Interleaved traffic across the pointer wrap against a reference queue
    for (int k = 0; k < 20; k++) begin
      logic wr, rd, wa, ra;
      wr = (k % 3) != 2;
      rd = (k % 2) == 1;
      wa = wr && (q.size() < 8 || rd);
      ra = rd && q.size() > 0;
      drive(wr, data_t'(8'h40 + k), rd);
      step();
      if (ra) begin
        exp_d = q.pop_front();
        chk("wrap_dout", bus.data_out, exp_d);
      end
      if (wa) q.push_back(data_t'(8'h40 + k));
      chk("wrap_count", bus.count, q.size());
    end

    while (q.size() < 5) begin
      drive(1'b1, 8'hC0, 1'b0);
      step();
      q.push_back(8'hC0);
    end
    while (q.size() > 5) begin
      drive(1'b0, '0, 1'b1);
      step();
      void'(q.pop_front());
    end
    drive(1'b0, '0, 1'b0);
    chk("pre_rst_count", bus.count, 5);

    // Asynchronous reset between edges
    #2;
    reset = 1'b0;
    #1;
    chk("arst_count", bus.count, 0);
    chk("arst_empty", bus.empty, 1);
    chk("arst_full", bus.full, 0);
    chk("arst_dout", bus.data_out, 0);
    q.delete();
    step();
    reset = 1'b1;
    step();
    chk("post_rst_empty", bus.empty, 1);
    drive(1'b1, 8'h77, 1'b0);
    step();
    drive(1'b0, '0, 1'b1);
    step();
    chk("post_rst_dout", bus.data_out, 8'h77);
    chk("post_rst_count", bus.count, 0);
    drive(1'b0, '0, 1'b0);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/modport_fifo.md
Name: modport_fifo

Overview:
- Synchronous single-clock FIFO: 8-bit data, depth 8.
- Registered read data; empty/full flags and an occupancy count.
- Sits between a producer driving wr_enb/data_in and a consumer driving rd_enb and sampling data_out.
- All inputs sampled on posedge clk; all outputs registered.

Parameters:
- DATA_W, 8, data word width.
- DEPTH, 8, number of storage entries; must be a power of two.
- CNT_W, 4, count width; equals log2(DEPTH)+1 so the value DEPTH is representable.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- reset  input  1  asynchronous active-low reset: asserts immediately, deasserts synchronously to clk.
- wr_enb  input  1  write request; data_in captured when accepted.
- data_in  input  DATA_W  write data.
- rd_enb  input  1  read request.
- data_out  output  DATA_W  read data, registered.
- empty  output  1  high when count==0.
- full  output  1  high when count==DEPTH.
- count  output  CNT_W  current occupancy, 0..DEPTH.

Behaviour:
- Reset (reset==0, async):
  - wr_ptr=0, rd_ptr=0, count=0, data_out=0, empty=1, full=0.
  - Memory contents are not cleared.
- Pointers:
  - log2(DEPTH) bits; wrap naturally from DEPTH-1 to 0.
  - Addresses are mem[wr_ptr] and mem[rd_ptr].
- Write accepted when wr_enb && (!full || rd_enb). Action: mem[wr_ptr]<=data_in; wr_ptr++.
- Read accepted when rd_enb && !empty.
  - Action: data_out<=mem[rd_ptr]; rd_ptr++.
  - Data is visible on data_out the cycle after the rd_enb edge (1-cycle latency).
- data_out holds its last value when no read is accepted.
- Count update:
  - +1 on write only, -1 on read only.
  - Unchanged when both are accepted or neither is.
- Flags are registered and derived from the next-state count, so they are consistent with count in the same cycle.
- Boundary cases:
  - Write when full, no read: dropped; memory, pointers and count unchanged.
  - Read when empty: ignored; data_out unchanged; pointers and count unchanged.
  - Full + wr + rd: both performed; count stays DEPTH; full stays 1.
  - Empty + wr + rd: only the write is performed; count becomes 1; data_out unchanged.
  - Reset mid-operation: all state returns to reset values at once; in-flight data is discarded.
- No combinational path from inputs to outputs.

Optional Feature:
- Macro: MODPORT_FIFO_ERR_FLAGS_EN.
- Defined:
  - Adds output overflow (1 bit): registered, set for exactly one cycle after a write is dropped because the FIFO is full.
  - Adds output underflow (1 bit): registered, set for exactly one cycle after a read is rejected because the FIFO is empty.
  - Both reset to 0.
- Undefined: these ports and their logic do not exist; core behaviour is identical.

Decomposition:
- Package modport_fifo_pkg holds:
  - localparams DATA_W=8, DEPTH=8, CNT_W=4, PTR_W=3;
  - typedef logic [DATA_W-1:0] data_t;
  - typedef logic [CNT_W-1:0] cnt_t.
- One sub-module, modport_fifo_mem: DEPTH x DATA_W register array with a write port and a registered read port.
- Pointer/count/flag control stays in the top module.

Test Plan:
- Reset: hold reset=0 for 2 cycles, then release -> empty=1, full=0, count=0, data_out=0.
- Fill then drain:
  - Write 0x11..0x88 on 8 consecutive cycles -> count 1..8, full=1 after the 8th write.
  - Then 8 reads -> data_out = 0x11..0x88 in order, one cycle after each rd_enb; empty=1, count=0 at the end.
- Overflow: when full, write 0xFF with rd_enb=0 -> count stays 8; subsequent drain never returns 0xFF; overflow pulses if MODPORT_FIFO_ERR_FLAGS_EN is defined.
- Underflow: when empty, assert rd_enb -> data_out holds its previous value, count stays 0, empty stays 1; underflow pulses if the macro is defined.
- Simultaneous read/write:
  - With count=4, wr 0xA5 plus rd -> count stays 4; the oldest word is output.
  - When full, wr plus rd -> count stays 8; the new word appears after the 7 remaining older words.
- Wrap-around and reset mid-stream:
  - 20 interleaved write/read cycles crossing the pointer wrap -> data matches a reference queue.
  - Assert reset while count=5 -> count=0, empty=1 immediately, without waiting for a clock edge.
